// File: rtl/kore_issue_sched_if.sv
// Handshake bundle between the IR fetch path, kore_issue_sched and the func FSM.
interface kore_issue_sched_if #(
  parameter int IW = 33
);
  logic          ir_valid;
  logic [IW-1:0] ir_data;
  logic          ir_ready;
  logic          eop;
  logic          op_start;
  logic          op_busy;
  logic [7:0]    op_func;
  logic [4:0]    op_rs0;
  logic [4:0]    op_rs1;
  logic [2:0]    op_bc;
  logic [4:0]    op_rd;
  logic [6:0]    opcode;

  // A word transfers on the rising clk edge where ir_valid && ir_ready; ir_valid
  // and ir_data must not depend on ir_ready, and ir_ready never depends on ir_valid.
  modport slave (
    input  ir_valid, ir_data, eop,
    output ir_ready, op_start, op_busy, op_func, op_rs0, op_rs1, op_bc, op_rd, opcode
  );

  modport master (
    output ir_valid, ir_data, eop,
    input  ir_ready, op_start, op_busy, op_func, op_rs0, op_rs1, op_bc, op_rd, opcode
  );
endinterface

// File: rtl/kore_issue_sched.sv
// Issue scheduler: instruction FIFO, bc==3'b111 issue FSM with eop/timeout completion.
// Optional macro KORE_ISSUE_PERF_EN adds the busy_cycles performance counter port.
module kore_issue_sched #(
  parameter int IW     = 33,
  parameter int DEPTH  = 4,
  parameter int TO_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  kore_issue_sched_if.slave      bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [15:0]            issued_cnt,
  output logic [7:0]             skip_cnt,
  output logic                   err_timeout,
  output logic [1:0]             state_dbg
`ifdef KORE_ISSUE_PERF_EN
  ,
  output logic [31:0]            busy_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] head;
  logic          push, pop, load, skip, normal, timeout;
  logic          op_start_q, op_busy_q;
  logic [7:0]    f_func;
  logic [4:0]    f_rs0, f_rs1, f_rd;
  logic [2:0]    f_bc;
  logic [6:0]    f_opcode;

  assign bus.ir_ready = (q_count < FULL_CNT);
  assign push         = bus.ir_valid && bus.ir_ready && !flush;
  assign head         = mem[rd_ptr];
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.ir_data;
  end

  // flush clears occupancy outright, so it overrides any push or pop this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    pop      = 1'b0;
    load     = 1'b0;
    skip     = 1'b0;
    normal   = 1'b0;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && (q_count != '0)) begin
          pop = 1'b1;
          if (head[14:12] == 3'b111) begin
            load     = 1'b1;
            state_nx = S_ISSUE;
          end else begin
            skip = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        timer_nx = '0;
        if (bus.eop) begin
          normal   = 1'b1;
          state_nx = S_DONE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_nx = timer + 1'b1;
        // eop takes priority over a timeout landing in the same cycle
        if (bus.eop) begin
          normal   = 1'b1;
          state_nx = S_DONE;
        end else if (timer == TO_LAST) begin
          timeout  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      op_start_q  <= 1'b0;
      op_busy_q   <= 1'b0;
      f_func      <= '0;
      f_rs0       <= '0;
      f_rs1       <= '0;
      f_bc        <= '0;
      f_rd        <= '0;
      f_opcode    <= '0;
      issued_cnt  <= '0;
      skip_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      op_start_q <= (state_nx == S_ISSUE);
      op_busy_q  <= (state_nx == S_ISSUE) || (state_nx == S_WAIT);
      if (load) begin
        f_func   <= head[32:25];
        f_rs0    <= head[24:20];
        f_rs1    <= head[19:15];
        f_bc     <= head[14:12];
        f_rd     <= head[11:7];
        f_opcode <= head[6:0];
      end
      if (skip && (skip_cnt != 8'hFF)) skip_cnt <= skip_cnt + 8'd1;
      if (normal)  issued_cnt  <= issued_cnt + 16'd1;
      if (timeout) err_timeout <= 1'b1;
    end
  end

`ifdef KORE_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         busy_cycles <= '0;
    else if (op_busy_q) busy_cycles <= busy_cycles + 32'd1;
  end
`endif

  assign bus.op_start = op_start_q;
  assign bus.op_busy  = op_busy_q;
  assign bus.op_func  = f_func;
  assign bus.op_rs0   = f_rs0;
  assign bus.op_rs1   = f_rs1;
  assign bus.op_bc    = f_bc;
  assign bus.op_rd    = f_rd;
  assign bus.opcode   = f_opcode;
endmodule

// File: tb/tb_kore_issue_sched.sv
// Directed and randomized checks of kore_issue_sched against an in-order issue/skip model.
module tb_kore_issue_sched;
  localparam int IW     = 33;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 8;
  localparam int QW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [QW-1:0] q_count;
  logic [15:0]   issued_cnt;
  logic [7:0]    skip_cnt;
  logic          err_timeout;
  logic [1:0]    state_dbg;
`ifdef KORE_ISSUE_PERF_EN
  logic [31:0]   busy_cycles;
`endif

  kore_issue_sched_if #(.IW(IW)) bus ();

  kore_issue_sched #(.IW(IW), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .q_count     (q_count),
    .issued_cnt  (issued_cnt),
    .skip_cnt    (skip_cnt),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
`ifdef KORE_ISSUE_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            pass_cnt  = 0;
  int            fail_cnt  = 0;
  int            total_cnt = 0;
  int            start_seen, busy_seen;
  logic [IW-1:0] exp_q[$];
  int            exp_issued, exp_skip;
  logic [IW-1:0] exp_w, w;
  logic          eop_wait;
  int            eop_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    if (bus.op_start) start_seen++;
    if (bus.op_busy)  busy_seen++;
  endtask

  task automatic wait_start(input string tag, input int bound);
    int n = 0;
    while (!bus.op_start && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bus.op_start), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q_count"}, 32'(q_count), 0);
    chk({tag, "_ir_ready"}, 32'(bus.ir_ready), 1);
    chk({tag, "_op_start"}, 32'(bus.op_start), 0);
    chk({tag, "_op_busy"}, 32'(bus.op_busy), 0);
    chk({tag, "_fields"}, 32'({bus.op_func, bus.op_rs0, bus.op_rs1, bus.op_bc, bus.op_rd}), 0);
    chk({tag, "_opcode"}, 32'(bus.opcode), 0);
    chk({tag, "_issued"}, 32'(issued_cnt), 0);
    chk({tag, "_skip"}, 32'(skip_cnt), 0);
    chk({tag, "_err"}, 32'(err_timeout), 0);
    chk({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  function automatic logic [IW-1:0] mk_word(input logic [7:0] f, input logic [4:0] r0,
                                            input logic [4:0] r1, input logic [2:0] bc,
                                            input logic [4:0] rd, input logic [6:0] opc);
    return {f, r0, r1, bc, rd, opc};
  endfunction

  // ---------------- directed then randomized steps ----------------
  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.ir_valid = 1'b0;
    bus.ir_data  = '0;
    bus.eop      = 1'b0;
    start_seen   = 0;
    busy_seen    = 0;

    // reset held two cycles
    cyc();
    cyc();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc();
    chk("rst_rel_ready", 32'(bus.ir_ready), 1);
    chk("rst_rel_q", 32'(q_count), 0);

    // single issue: eop three cycles after op_start
    bus.ir_valid = 1'b1;
    bus.ir_data  = 33'h0_0000_7013;
    cyc();
    bus.ir_valid = 1'b0;
    chk("t1_no_early_start", 32'(bus.op_start), 0);
    chk("t1_q_after_push", 32'(q_count), 1);
    busy_seen  = 0;
    start_seen = 0;
    cyc();
    chk("t1_start", 32'(bus.op_start), 1);
    chk("t1_opcode", 32'(bus.opcode), 32'h13);
    chk("t1_bc", 32'(bus.op_bc), 7);
    cyc();
    chk("t1_start_pulse", 32'(bus.op_start), 0);
    cyc();
    cyc();
    bus.eop = 1'b1;
    cyc();
    bus.eop = 1'b0;
    chk("t1_done_not_busy", 32'(bus.op_busy), 0);
    cyc();
    chk("t1_busy_cycles", 32'(busy_seen), 4);
    chk("t1_one_start", 32'(start_seen), 1);
    chk("t1_issued", 32'(issued_cnt), 1);
    chk("t1_opcode_held", 32'(bus.opcode), 32'h13);
`ifdef KORE_ISSUE_PERF_EN
    chk("t1_perf_busy", busy_cycles, 4);
`endif

    // skip words back up behind a running op until ir_ready drops
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'hA5, 5'd1, 5'd2, 3'b111, 5'd3, 7'h33);
    cyc();
    bus.ir_data = mk_word(8'h11, 5'd4, 5'd5, 3'b000, 5'd6, 7'h01);
    cyc();
    chk("t2_start", 32'(bus.op_start), 1);
    chk("t2_func", 32'(bus.op_func), 32'hA5);
    bus.ir_data = mk_word(8'h12, 5'd4, 5'd5, 3'b000, 5'd6, 7'h02);
    cyc();
    bus.ir_data = mk_word(8'h13, 5'd4, 5'd5, 3'b000, 5'd6, 7'h03);
    cyc();
    bus.ir_data = mk_word(8'h14, 5'd4, 5'd5, 3'b000, 5'd6, 7'h04);
    cyc();
    chk("t2_full_q", 32'(q_count), 4);
    chk("t2_full_ready", 32'(bus.ir_ready), 0);
    bus.ir_data = mk_word(8'h15, 5'd4, 5'd5, 3'b000, 5'd6, 7'h05);
    cyc();
    chk("t2_held_q", 32'(q_count), 4);
    chk("t2_held_ready", 32'(bus.ir_ready), 0);
    bus.eop = 1'b1;
    cyc();
    bus.eop      = 1'b0;
    bus.ir_valid = 1'b0;
    chk("t2_done_q", 32'(q_count), 4);
    start_seen = 0;
    repeat (8) cyc();
    chk("t2_skip", 32'(skip_cnt), 4);
    chk("t2_q_empty", 32'(q_count), 0);
    chk("t2_no_start", 32'(start_seen), 0);
    chk("t2_issued", 32'(issued_cnt), 2);
    chk("t2_func_held", 32'(bus.op_func), 32'hA5);

    // eop in the ISSUE cycle
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h3C, 5'd7, 5'd8, 3'b111, 5'd9, 7'h0B);
    cyc();
    bus.ir_valid = 1'b0;
    busy_seen    = 0;
    cyc();
    chk("t3_start", 32'(bus.op_start), 1);
    bus.eop = 1'b1;
    cyc();
    bus.eop = 1'b0;
    chk("t3_done_idle", 32'(bus.op_busy), 0);
    cyc();
    chk("t3_busy_one", 32'(busy_seen), 1);
    chk("t3_issued", 32'(issued_cnt), 3);

    // eop arriving in the very cycle the timeout would fire
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h44, 5'd1, 5'd1, 3'b111, 5'd1, 7'h44);
    cyc();
    bus.ir_valid = 1'b0;
    busy_seen    = 0;
    cyc();
    chk("t4_start", 32'(bus.op_start), 1);
    repeat (TO_CYC) cyc();
    chk("t4_last_wait_busy", 32'(bus.op_busy), 1);
    bus.eop = 1'b1;
    cyc();
    bus.eop = 1'b0;
    chk("t4_done", 32'(bus.op_busy), 0);
    cyc();
    chk("t4_busy_len", 32'(busy_seen), TO_CYC + 1);
    chk("t4_issued", 32'(issued_cnt), 4);
    chk("t4_no_err", 32'(err_timeout), 0);

    // timeout, then the queued word still issues
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h55, 5'd2, 5'd3, 3'b111, 5'd9, 7'h55);
    cyc();
    bus.ir_data = mk_word(8'h66, 5'd4, 5'd5, 3'b111, 5'd17, 7'h66);
    cyc();
    bus.ir_valid = 1'b0;
    chk("t5_start", 32'(bus.op_start), 1);
    chk("t5_rd", 32'(bus.op_rd), 9);
    repeat (TO_CYC) cyc();
    chk("t5_pre_err", 32'(err_timeout), 0);
    chk("t5_pre_busy", 32'(bus.op_busy), 1);
    cyc();
    chk("t5_err", 32'(err_timeout), 1);
    chk("t5_done", 32'(bus.op_busy), 0);
    cyc();
    chk("t5_issued_same", 32'(issued_cnt), 4);
    wait_start("t5_next_start", 4);
    chk("t5_next_rd", 32'(bus.op_rd), 17);
    chk("t5_next_func", 32'(bus.op_func), 32'h66);
    bus.eop = 1'b1;
    cyc();
    bus.eop = 1'b0;
    cyc();
    chk("t5_issued_next", 32'(issued_cnt), 5);
    chk("t5_err_sticky", 32'(err_timeout), 1);

    // flush during WAIT, coincident push dropped, op still completes
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h77, 5'd1, 5'd2, 3'b111, 5'd3, 7'h77);
    cyc();
    bus.ir_valid = 1'b0;
    cyc();
    chk("t6_start", 32'(bus.op_start), 1);
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h81, 5'd0, 5'd0, 3'b111, 5'd0, 7'h01);
    cyc();
    bus.ir_data = mk_word(8'h82, 5'd0, 5'd0, 3'b111, 5'd0, 7'h02);
    cyc();
    bus.ir_data = mk_word(8'h83, 5'd0, 5'd0, 3'b111, 5'd0, 7'h03);
    cyc();
    chk("t6_q3", 32'(q_count), 3);
    flush       = 1'b1;
    bus.ir_data = mk_word(8'h84, 5'd0, 5'd0, 3'b111, 5'd0, 7'h04);
    cyc();
    flush        = 1'b0;
    bus.ir_valid = 1'b0;
    chk("t6_flushed", 32'(q_count), 0);
    chk("t6_still_busy", 32'(bus.op_busy), 1);
    bus.eop = 1'b1;
    cyc();
    bus.eop    = 1'b0;
    start_seen = 0;
    repeat (6) cyc();
    chk("t6_issued", 32'(issued_cnt), 6);
    chk("t6_no_start", 32'(start_seen), 0);
    chk("t6_q_empty", 32'(q_count), 0);
    chk("t6_func_held", 32'(bus.op_func), 32'h77);

    // reset mid-operation drops everything
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h99, 5'd3, 5'd3, 3'b111, 5'd3, 7'h19);
    cyc();
    bus.ir_valid = 1'b0;
    cyc();
    chk("t7_start", 32'(bus.op_start), 1);
    bus.ir_valid = 1'b1;
    bus.ir_data  = mk_word(8'h9A, 5'd3, 5'd3, 3'b111, 5'd3, 7'h1A);
    cyc();
    bus.ir_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk_reset_vals("t7");
    rst_n      = 1'b1;
    start_seen = 0;
    repeat (5) cyc();
    chk("t7_lost", 32'(start_seen), 0);

    // randomized traffic against the in-order issue/skip model
    exp_issued = 0;
    exp_skip   = 0;
    eop_wait   = 1'b0;
    eop_cnt    = 0;
    for (int c = 0; c < 800; c++) begin
      cyc();
      bus.eop = 1'b0;
      if (bus.op_start) begin
        if (exp_q.size() != 0) exp_w = exp_q.pop_front();
        else exp_w = '0;
        chk("rnd_func", 32'(bus.op_func), 32'(exp_w[32:25]));
        chk("rnd_fields", 32'({bus.op_rs0, bus.op_rs1, bus.op_bc, bus.op_rd, bus.opcode}),
            32'(exp_w[24:0]));
        eop_wait = 1'b1;
        eop_cnt  = $urandom_range(0, TO_CYC);
      end
      if (eop_wait) begin
        if (eop_cnt == 0) begin
          bus.eop  = 1'b1;
          eop_wait = 1'b0;
          exp_issued++;
        end else begin
          eop_cnt--;
        end
      end
      w = IW'({$urandom, $urandom});
      if (c < 400) begin
        bus.ir_valid = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 1) == 1) w[14:12] = 3'b111;
        else w[14:12] = 3'($urandom_range(0, 6));
      end else if (c < 700) begin
        bus.ir_valid = 1'b1;
        w[14:12]     = 3'b010;
      end else begin
        bus.ir_valid = 1'b0;
      end
      bus.ir_data = w;
      if (bus.ir_valid && bus.ir_ready) begin
        if (w[14:12] == 3'b111) exp_q.push_back(w);
        else exp_skip++;
      end
    end
    bus.eop      = 1'b0;
    bus.ir_valid = 1'b0;
    cyc();
    chk("rnd_all_issued", 32'(exp_q.size()), 0);
    chk("rnd_issued_cnt", 32'(issued_cnt), 32'(exp_issued % 65536));
    chk("rnd_skip_sat", 32'(skip_cnt), (exp_skip > 255) ? 255 : exp_skip);
    chk("rnd_no_err", 32'(err_timeout), 0);
    chk("rnd_q_empty", 32'(q_count), 0);
    chk("rnd_idle", 32'(bus.op_busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/kore_issue_sched.md
Name: kore_issue_sched

Overview:
- Instruction issue scheduler placed between the IR fetch path and the op-decode/func-FSM pair.
- Buffers incoming 33-bit instruction words in a small FIFO and splits each dispatched word into its fields.
- Issues only branch/compute words (bc == 3'b111) to the functional unit, one at a time, and holds the unit busy until end-of-operation (eop).
- Discards non-executable words and guards every issue with a timeout watchdog.

Parameters:
IW, 33, instruction word width; fields at [32:25] func8, [24:20] rs0, [19:15] rs1, [14:12] bc, [11:7] rd, [6:0] opcode
DEPTH, 4, FIFO entries; must be a power of 2, at least 2
TO_CYC, 255, maximum WAIT cycles before a timeout is declared; at least 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ir_valid  in  1  instruction word offered
ir_data  in  IW  instruction word
ir_ready  out  1  FIFO can accept; equals (q_count < DEPTH)
flush  in  1  synchronous FIFO clear
eop  in  1  end of operation from the func FSM
op_start  out  1  one-cycle issue pulse
op_busy  out  1  operation in flight (level)
op_func  out  8  func8 of the issued word
op_rs0  out  5  rs0 field
op_rs1  out  5  rs1 field
op_bc  out  3  bc field
op_rd  out  5  rd field
opcode  out  7  opcode field
q_count  out  $clog2(DEPTH)+1  FIFO occupancy
issued_cnt  out  16  count of normally completed operations
skip_cnt  out  8  count of discarded non-executable words
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: every output register is 0. The FIFO is empty, the FSM is in IDLE, and the timer is 0. ir_ready is 1 out of reset because it is derived from q_count.
- Push occurs when ir_valid && ir_ready. There is no bypass: a word pushed in cycle N is visible at the head in cycle N+1.
- flush empties the FIFO in the same cycle. flush wins over a simultaneous push (the word is dropped) and over a simultaneous pop. flush does not abort an operation already issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If the FIFO is non-empty and the head bc != 3'b111: pop the head, increment skip_cnt (saturates at 255), stay in IDLE. This gives one discard per cycle.
  - If the FIFO is non-empty and the head bc == 3'b111: pop the head, load all six field registers from it, go to ISSUE.
  - If the FIFO is empty: stay in IDLE.
- ISSUE: lasts exactly 1 cycle. op_start = 1 and op_busy = 1. The timer clears. If eop is high in this cycle, go to DONE; otherwise go to WAIT.
- WAIT: op_busy = 1 and the timer increments each cycle.
  - eop = 1: go to DONE as a normal completion.
  - Otherwise, when the timer reaches TO_CYC: set err_timeout and go to DONE as an abnormal completion.
  - If eop and the timeout occur in the same cycle, eop wins.
- DONE: lasts 1 cycle with op_busy = 0, giving a mandatory gap between operations. issued_cnt increments (wrapping at 2^16) only on a normal completion. Next state is IDLE.
- Issue latency: a word pushed at cycle N into an empty FIFO while the FSM is in IDLE loads its fields at the N+1→N+2 edge. op_start and op_busy are high in cycle N+2.
- Field outputs and output flags are registered. Field outputs change only on an IDLE→ISSUE load and are otherwise held, including through DONE and IDLE.
- eop is ignored in IDLE and DONE.
- err_timeout is cleared only by reset.
- Reset asserted mid-operation returns everything to the reset values immediately; queued words are lost.

Optional Feature:
- Macro: KORE_ISSUE_PERF_EN.
- Defined: adds output port busy_cycles (out, 32). It counts every cycle with op_busy = 1, wraps at 2^32, and resets to 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n = 0 for 2 cycles -> all outputs 0, ir_ready = 1, q_count = 0.
- Single issue: push 33'h0_0000_7013 (bc = 3'b111), assert eop 3 cycles after op_start -> op_start pulse 2 cycles after push; opcode = 7'h13, op_bc = 3'b111; op_busy high 4 cycles; issued_cnt = 1.
- Skip plus backpressure: push 4 words with bc = 3'b000 while holding ir_valid -> ir_ready drops when q_count = 4; all 4 discarded, skip_cnt = 4, no op_start.
- Timeout: TO_CYC = 8, issue a word, never assert eop -> err_timeout set 8 cycles into WAIT; issued_cnt unchanged; next queued word still issues.
- Flush during WAIT: 3 words queued, pulse flush -> q_count = 0 next cycle; in-flight op completes on eop with issued_cnt +1; flush coincident with a push drops that word.
- Edge cases: eop in the ISSUE cycle -> DONE next cycle with busy for 1 cycle; eop and timeout in the same cycle -> counted normal, err_timeout stays 0.
